mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Sits directly upstream of the 2-way write-back cache controller. Converts core load/store requests into single-beat AXI4-Lite-style transactions on the cache's MMU-side port.
- Handles byte, halfword and word accesses. Generates write strobes and lane-shifted write data. Extracts and sign- or zero-extends read data.
- Rejects misaligned accesses without issuing any bus transaction. Holds exactly one outstanding transaction.

Parameters:
- ADDR_W, 32, core and AXI address width
- DATA_W, 32, data width; only 32 is supported

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, asynchronous, active-low
- req_valid  in  1  core request valid
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal
- req_signed  in  1  sign-extend load result
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  response valid
- rsp_ready  in  1  core accepts response
- rsp_rdata  out  32  extended load data; 0 for stores
- rsp_err  out  1  misaligned, illegal size, or bus error
- m_axi_araddr  out  32  word-aligned read address
- m_axi_arvalid  out  1
- m_axi_arready  in  1
- m_axi_rdata  in  32
- m_axi_rresp  in  2
- m_axi_rvalid  in  1
- m_axi_rready  out  1
- m_axi_awaddr  out  32  word-aligned write address
- m_axi_awvalid  out  1
- m_axi_awready  in  1
- m_axi_wdata  out  32  lane-shifted data
- m_axi_wstrb  out  4
- m_axi_wvalid  out  1
- m_axi_wready  in  1
- m_axi_bresp  in  2
- m_axi_bvalid  in  1
- m_axi_bready  out  1

Behaviour:
- Reset: clock is clk; rstn is asynchronous active-low. While rstn is low:
  - all valid/ready outputs are 0, rsp_rdata = 0, rsp_err = 0
  - address, wdata and wstrb outputs are 0
  - state = IDLE
  - Reset mid-transaction drops it silently; the downstream cache is reset by the same rstn.
- IDLE:
  - req_ready = 1. On req_valid, latch we/size/signed/addr[1:0]/wdata.
  - Alignment check:
    - half requires addr[0] = 0
    - word requires addr[1:0] = 0
    - size 3 is illegal
  - Illegal request → RESP with rsp_err = 1, no bus activity. Latency 1 cycle.
  - Load → RD_A. Drive araddr = {addr[31:2], 2'b00}, arvalid = 1.
  - Store → WR_AW:
    - drive awaddr (word-aligned) and awvalid = 1
    - drive wvalid = 1 in the same cycle
    - wdata = req_wdata << (8 * addr[1:0])
    - wstrb = byte 4'b0001 << addr[1:0]; half 4'b0011 << addr[1:0]; word 4'b1111
- RD_A:
  - Hold arvalid and araddr stable until arready is sampled high; the cache asserts arready only intermittently.
  - Then arvalid = 0, rready = 1, go to RD_D.
- RD_D:
  - On rvalid: rready = 0. Capture rdata >> (8 * addr[1:0]), then truncate to size.
  - Sign-extend if req_signed, else zero-extend. Word ignores req_signed.
  - rsp_err = rresp[1]. Go to RESP.
- WR_AW:
  - AW and W handshake independently. Each valid drops on its own ready.
  - awready and wready may arrive on different cycles, in either order, or together.
  - When both have completed, bready = 1 and go to WR_B.
- WR_B: on bvalid, bready = 0, rsp_err = bresp[1], rsp_rdata = 0, go to RESP.
- RESP:
  - rsp_valid = 1 and held until rsp_ready.
  - On rsp_ready, clear rsp_valid and go to IDLE. req_ready returns high the cycle after.
- No request overlap: req_ready = 0 in every state except IDLE.
- Outputs are registered. The minimum load path is IDLE → RD_A → RD_D → RESP.

Optional Feature:
- MEM_ACCESS_TIMEOUT_EN defined: a 16-bit counter runs in RD_A, RD_D, WR_AW and WR_B and clears on every state change.
  - On reaching 16'hFFFF, the unit deasserts all bus valids/readies and goes to RESP with rsp_err = 1.
  - It also sets the sticky output port timeout_err (1 bit), which is cleared only by reset.
- Undefined: no counter and no timeout_err port; the unit waits indefinitely.

Decomposition:
- Shared package mem_pkg:
  - size encodings SZ_BYTE / SZ_HALF / SZ_WORD
  - AXI response codes RESP_OKAY / RESP_SLVERR
  - state enum
  - timeout width constant
- One natural sub-module, mem_lane_align: combinational.
  - Inputs: size, addr[1:0], signed, wdata, rdata.
  - Outputs: wstrb, shifted wdata, extended rdata, misaligned flag.
  - Unit-testable on its own.

Test Plan:
- Load word at 0x100 with the cache returning 0xDEADBEEF: araddr = 0x100, rsp_rdata = 0xDEADBEEF, rsp_err = 0.
- Signed byte load at 0x103 with rdata 0x80112233: rsp_rdata = 0xFFFFFF80. Same access unsigned: rsp_rdata = 0x00000080.
- Half store 0x1234 at 0x202: awaddr = 0x200, wdata = 0x12340000, wstrb = 4'b1100. Test twice: awready 3 cycles before wready, then wready first. rsp_valid follows bvalid.
- Word load at 0x101: no arvalid ever asserted, rsp_err = 1 one cycle after acceptance.
- arready toggling 0/1 with arvalid held: exactly one AR handshake. rresp = 2'b10 gives rsp_err = 1.
- rstn pulsed low during WR_B: all outputs 0 immediately (asynchronous). After release req_ready = 1, and a subsequent load completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the memory access unit: access sizes, AXI response codes, FSM states.
package mem_pkg;
   localparam logic [1:0] SZ_BYTE     = 2'd0;
   localparam logic [1:0] SZ_HALF     = 2'd1;
   localparam logic [1:0] SZ_WORD     = 2'd2;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam int         TMO_W       = 16;

   typedef enum logic [2:0] {
      IDLE, RD_A, RD_D, WR_AW, WR_B, RESP
   } state_t;
endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store strobes/data shift, load extract/extend, alignment check.
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  off,
   input  logic        sext,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata_sh,
   output logic [31:0] rdata_ext,
   output logic        misalign
);
   logic [31:0] rsh;

   always_comb begin
      rsh       = rdata >> {off, 3'b000};
      wdata_sh  = wdata << {off, 3'b000};
      wstrb     = 4'b1111;
      rdata_ext = rsh;
      misalign  = 1'b0;
      case (size)
         SZ_BYTE: begin
            wstrb     = 4'b0001 << off;
            rdata_ext = {{24{sext & rsh[7]}}, rsh[7:0]};
         end
         SZ_HALF: begin
            misalign  = off[0];
            wstrb     = 4'b0011 << off;
            rdata_ext = {{16{sext & rsh[15]}}, rsh[15:0]};
         end
         SZ_WORD: misalign = |off;
         // size 3 is folded into the reject flag
         default: misalign = 1'b1;
      endcase
   end
endmodule

// File: rtl/mem_access_unit.sv
// Core load/store to single-beat AXI4-Lite bridge, one outstanding transaction, registered outputs.
// Optional watchdog: define MEM_ACCESS_TIMEOUT_EN to add the bus timeout and timeout_err port.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] m_axi_araddr,
   output logic              m_axi_arvalid,
   input  logic              m_axi_arready,
   input  logic [DATA_W-1:0] m_axi_rdata,
   input  logic [1:0]        m_axi_rresp,
   input  logic              m_axi_rvalid,
   output logic              m_axi_rready,
   output logic [ADDR_W-1:0] m_axi_awaddr,
   output logic              m_axi_awvalid,
   input  logic              m_axi_awready,
   output logic [DATA_W-1:0] m_axi_wdata,
   output logic [3:0]        m_axi_wstrb,
   output logic              m_axi_wvalid,
   input  logic              m_axi_wready,
   input  logic [1:0]        m_axi_bresp,
   input  logic              m_axi_bvalid,
`ifdef MEM_ACCESS_TIMEOUT_EN
   output logic              timeout_err,
`endif
   output logic              m_axi_bready
);
   state_t            state_q, state_d;
   logic              req_ready_d, rsp_valid_d, rsp_err_d;
   logic [DATA_W-1:0] rsp_rdata_d, wdata_d;
   logic [ADDR_W-1:0] araddr_d, awaddr_d;
   logic              arvalid_d, rready_d, awvalid_d, wvalid_d, bready_d;
   logic [3:0]        wstrb_d;
   logic [1:0]        size_q, size_d, off_q, off_d;
   logic              sext_q, sext_d;

   logic [1:0]  la_size, la_off;
   logic        la_sext, la_misalign;
   logic [3:0]  la_wstrb;
   logic [31:0] la_wdata, la_rdata;
   logic        unused_resp;

   assign unused_resp = m_axi_rresp[0] ^ m_axi_bresp[0];

   // In IDLE the aligner sees the live request; afterwards it sees the latched access.
   assign la_size = (state_q == IDLE) ? req_size      : size_q;
   assign la_off  = (state_q == IDLE) ? req_addr[1:0] : off_q;
   assign la_sext = (state_q == IDLE) ? req_signed    : sext_q;

   mem_lane_align u_align (
      .size(la_size), .off(la_off), .sext(la_sext),
      .wdata(req_wdata), .rdata(m_axi_rdata),
      .wstrb(la_wstrb), .wdata_sh(la_wdata), .rdata_ext(la_rdata), .misalign(la_misalign)
   );

`ifdef MEM_ACCESS_TIMEOUT_EN
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             tmo_err_d, busy;
   assign busy = (state_q == RD_A) || (state_q == RD_D) || (state_q == WR_AW) || (state_q == WR_B);
`endif

   always_comb begin
      state_d     = state_q;
      rsp_valid_d = rsp_valid;
      rsp_err_d   = rsp_err;
      rsp_rdata_d = rsp_rdata;
      araddr_d    = m_axi_araddr;
      arvalid_d   = m_axi_arvalid;
      rready_d    = m_axi_rready;
      awaddr_d    = m_axi_awaddr;
      awvalid_d   = m_axi_awvalid;
      wdata_d     = m_axi_wdata;
      wstrb_d     = m_axi_wstrb;
      wvalid_d    = m_axi_wvalid;
      bready_d    = m_axi_bready;
      size_d      = size_q;
      off_d       = off_q;
      sext_d      = sext_q;
      case (state_q)
         IDLE: if (req_valid && req_ready) begin
            size_d = req_size;
            off_d  = req_addr[1:0];
            sext_d = req_signed;
            if (la_misalign) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
               state_d     = RESP;
            end else if (req_we) begin
               awaddr_d  = {req_addr[ADDR_W-1:2], 2'b00};
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               wdata_d   = la_wdata;
               wstrb_d   = la_wstrb;
               state_d   = WR_AW;
            end else begin
               araddr_d  = {req_addr[ADDR_W-1:2], 2'b00};
               arvalid_d = 1'b1;
               state_d   = RD_A;
            end
         end
         RD_A: if (m_axi_arready) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b1;
            state_d   = RD_D;
         end
         RD_D: if (m_axi_rvalid) begin
            rready_d    = 1'b0;
            rsp_rdata_d = la_rdata;
            rsp_err_d   = m_axi_rresp[1];
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         WR_AW: begin
            if (m_axi_awready) awvalid_d = 1'b0;
            if (m_axi_wready)  wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = WR_B;
            end
         end
         WR_B: if (m_axi_bvalid) begin
            bready_d    = 1'b0;
            rsp_err_d   = m_axi_bresp[1];
            rsp_rdata_d = '0;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: if (rsp_ready) begin
            rsp_valid_d = 1'b0;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
`ifdef MEM_ACCESS_TIMEOUT_EN
      tmo_err_d = timeout_err;
      if (busy && (tmo_cnt_q == '1)) begin
         arvalid_d   = 1'b0;
         rready_d    = 1'b0;
         awvalid_d   = 1'b0;
         wvalid_d    = 1'b0;
         bready_d    = 1'b0;
         rsp_valid_d = 1'b1;
         rsp_err_d   = 1'b1;
         rsp_rdata_d = '0;
         tmo_err_d   = 1'b1;
         state_d     = RESP;
      end
      tmo_cnt_d = (!busy || (state_d != state_q)) ? '0 : tmo_cnt_q + 1'b1;
`endif
      req_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= IDLE;
         req_ready     <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_err       <= 1'b0;
         rsp_rdata     <= '0;
         m_axi_araddr  <= '0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
         m_axi_awaddr  <= '0;
         m_axi_awvalid <= 1'b0;
         m_axi_wdata   <= '0;
         m_axi_wstrb   <= '0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         size_q        <= '0;
         off_q         <= '0;
         sext_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         req_ready     <= req_ready_d;
         rsp_valid     <= rsp_valid_d;
         rsp_err       <= rsp_err_d;
         rsp_rdata     <= rsp_rdata_d;
         m_axi_araddr  <= araddr_d;
         m_axi_arvalid <= arvalid_d;
         m_axi_rready  <= rready_d;
         m_axi_awaddr  <= awaddr_d;
         m_axi_awvalid <= awvalid_d;
         m_axi_wdata   <= wdata_d;
         m_axi_wstrb   <= wstrb_d;
         m_axi_wvalid  <= wvalid_d;
         m_axi_bready  <= bready_d;
         size_q        <= size_d;
         off_q         <= off_d;
         sext_q        <= sext_d;
      end
   end

`ifdef MEM_ACCESS_TIMEOUT_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tmo_cnt_q   <= '0;
         timeout_err <= 1'b0;
      end else begin
         tmo_cnt_q   <= tmo_cnt_d;
         timeout_err <= tmo_err_d;
      end
   end
`endif
endmodule
